// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if
// Purpose : groups the two requester handshakes and the response/status
//           signals of adder_share_arb into one bundle.
// Signals :
//   req0/a0/b0/gnt0   requester 0 request, operands and grant pulse
//   req1/a1/b1/gnt1   requester 1 request, operands and grant pulse
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout  response handshake and payload
//   busy              arbiter is executing or holding a response
//   done_cnt          completed response handshakes (wrapping)
// Modports: slave  - the arbiter side
//           master - requesters, consumer and status observer
interface adder_share_arb_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ready;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, done_cnt
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy, done_cnt
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb
// Purpose : shares one 4-bit combinational adder between two requesters
//           using round-robin arbitration. The winner's operands are
//           registered, added in the following cycle, and the result is held
//           in a response register until the consumer accepts it.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - adder_share_arb_if.slave: requests/operands/grants of both
//          requesters, response handshake, busy and done_cnt
// Parameters:
//   WIDTH - operand/sum width, must be 4 to match the shared adder
//   CNT_W - width of the completed-operation counter
module adder_share_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_share_arb_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q;
    logic             last_grant_q;
    logic             op_id_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             busy_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic             win_id_s;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_d;
    logic [WIDTH-1:0] add_sum_s;
    logic             add_cout_s;

    // Shared adder: only ever sees the registered operands.
    adder u_adder (
        .a    (op_a_q),
        .b    (op_b_q),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Round-robin winner and its operands; on a tie the requester that did
    // not win last time is chosen.
    always_comb begin
        win_id_s = 1'b0;
        op_a_d   = bus.a0;
        op_b_d   = bus.b0;
        if (bus.req0 && bus.req1) begin
            win_id_s = ~last_grant_q;
        end else if (bus.req1) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
        if (win_id_s) begin
            op_a_d = bus.a1;
            op_b_d = bus.b1;
        end else begin
            op_a_d = bus.a0;
            op_b_d = bus.b0;
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_id_q      <= 1'b0;
            op_a_q       <= {WIDTH{1'b0}};
            op_b_q       <= {WIDTH{1'b0}};
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= {WIDTH{1'b0}};
            rsp_cout_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            // Grants are single-cycle pulses unless re-asserted below.
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        op_a_q       <= op_a_d;
                        op_b_q       <= op_b_d;
                        op_id_q      <= win_id_s;
                        last_grant_q <= win_id_s;
                        gnt0_q       <= ~win_id_s;
                        gnt1_q       <= win_id_s;
                        busy_q       <= 1'b1;
                        state_q      <= ST_EXEC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_sum_q   <= add_sum_s;
                    rsp_cout_q  <= add_cout_s;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        // Payload registers keep their values after the handshake.
                        rsp_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.busy      = busy_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// adder
// Purpose : 4-bit combinational adder shared by adder_share_arb.
// Ports   : a, b - operands; sum - 4-bit sum; cout - carry out
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic       id;
        logic [3:0] sum;
        logic       cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_share_arb_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    adder_share_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_gnt_cyc = 0;
    logic [7:0] exp_done = 8'd0;
    logic       model_last = 1'b1;
    logic [3:0] hold_sum;
    logic       hold_cout;
    logic       hold_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every response handshake is compared with the
    // oldest expected result; reset discards any pending result.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            sb_q.delete();
            exp_done <= 8'd0;
        end else if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, mon_e.id});
                check("rsp_sum", {28'd0, bus.rsp_sum}, {28'd0, mon_e.sum});
                check("rsp_cout", {31'd0, bus.rsp_cout}, {31'd0, mon_e.cout});
            end
            exp_done <= exp_done + 8'd1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pred(input logic r0, input logic r1);
        if (r0 && r1) return ~model_last;
        return r1;
    endfunction

    // Grant is visible now: verify it and push the expected result.
    task automatic take_gnt(input logic exp_w, input bit chk_gap);
        exp_t       e;
        logic [4:0] s5;
        check("gnt_id", {31'd0, bus.gnt1}, {31'd0, exp_w});
        check("gnt_onehot", {31'd0, bus.gnt0 ^ bus.gnt1}, 32'd1);
        if (chk_gap) check("gnt_gap", cyc - last_gnt_cyc, 32'd3);
        last_gnt_cyc = cyc;
        if (exp_w) s5 = {1'b0, bus.a1} + {1'b0, bus.b1};
        else       s5 = {1'b0, bus.a0} + {1'b0, bus.b0};
        e.id   = exp_w;
        e.sum  = s5[3:0];
        e.cout = s5[4];
        sb_q.push_back(e);
        model_last = exp_w;
    endtask

    task automatic wait_gnt(input logic exp_w, input bit chk_gap);
        int k;
        k = 0;
        tick();
        while (!(bus.gnt0 || bus.gnt1) && k < 12) begin
            tick();
            k++;
        end
        check("gnt_timeout", {31'd0, bus.gnt0 | bus.gnt1}, 32'd1);
        if (bus.gnt0 || bus.gnt1) take_gnt(exp_w, chk_gap);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        tick();
        while ((bus.busy || bus.rsp_valid) && k < 20) begin
            tick();
            k++;
        end
        check("idle_timeout", {31'd0, bus.busy | bus.rsp_valid}, 32'd0);
        check("done_cnt", {24'd0, bus.done_cnt}, {24'd0, exp_done});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt0"}, {31'd0, bus.gnt0}, 32'd0);
        check({tag, "_gnt1"}, {31'd0, bus.gnt1}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_id"}, {31'd0, bus.rsp_id}, 32'd0);
        check({tag, "_sum"}, {28'd0, bus.rsp_sum}, 32'd0);
        check({tag, "_cout"}, {31'd0, bus.rsp_cout}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {24'd0, bus.done_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0;
        bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0;
        bus.rsp_ready = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        model_last = 1'b1;

        // Single add on requester 0
        bus.rsp_ready = 1'b1;
        bus.a0 = 4'b0001; bus.b0 = 4'b0010; bus.req0 = 1'b1;
        wait_gnt(pred(1'b1, 1'b0), 1'b0);
        check("busy_exec", {31'd0, bus.busy}, 32'd1);
        bus.req0 = 1'b0;
        tick();
        check("gnt0_pulse", {31'd0, bus.gnt0}, 32'd0);
        check("valid_after_exec", {31'd0, bus.rsp_valid}, 32'd1);
        wait_idle();

        // No carry, all ones on requester 0
        bus.a0 = 4'b0101; bus.b0 = 4'b1010; bus.req0 = 1'b1;
        wait_gnt(pred(1'b1, 1'b0), 1'b0);
        bus.req0 = 1'b0;
        wait_idle();

        // Carry out on requester 1
        bus.a1 = 4'b1111; bus.b1 = 4'b0001; bus.req1 = 1'b1;
        wait_gnt(pred(1'b0, 1'b1), 1'b0);
        bus.req1 = 1'b0;
        wait_idle();

        // Contention: both held, expect 0,1,0,1 spaced 3 cycles apart
        bus.a0 = 4'd3; bus.b0 = 4'd4; bus.a1 = 4'd9; bus.b1 = 4'd8;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rr_order", {31'd0, pred(1'b1, 1'b1)}, i % 2);
            wait_gnt(pred(1'b1, 1'b1), i > 0);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();

        // Backpressure: response held, requester 1 waits
        bus.rsp_ready = 1'b0;
        bus.a0 = 4'd7; bus.b0 = 4'd6; bus.req0 = 1'b1;
        wait_gnt(pred(1'b1, 1'b0), 1'b0);
        bus.req0 = 1'b0;
        bus.a1 = 4'd2; bus.b1 = 4'd2; bus.req1 = 1'b1;
        tick();
        hold_sum = bus.rsp_sum; hold_cout = bus.rsp_cout; hold_id = bus.rsp_id;
        check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("bp_sum_val", {28'd0, hold_sum}, 32'd13);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_sum_hold", {28'd0, bus.rsp_sum}, {28'd0, hold_sum});
            check("bp_cout_hold", {31'd0, bus.rsp_cout}, {31'd0, hold_cout});
            check("bp_id_hold", {31'd0, bus.rsp_id}, {31'd0, hold_id});
            check("bp_no_gnt1", {31'd0, bus.gnt1}, 32'd0);
            check("bp_busy", {31'd0, bus.busy}, 32'd1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_gnt1_early", {31'd0, bus.gnt1}, 32'd0);
        tick();
        check("bp_gnt1_late", {31'd0, bus.gnt1}, 32'd1);
        if (bus.gnt1) take_gnt(1'b1, 1'b0);
        bus.req1 = 1'b0;
        wait_idle();

        // Reset while a response is pending
        bus.rsp_ready = 1'b0;
        bus.a0 = 4'd9; bus.b0 = 4'd9; bus.req0 = 1'b1;
        wait_gnt(pred(1'b1, 1'b0), 1'b0);
        bus.req0 = 1'b0;
        tick();
        check("mid_valid", {31'd0, bus.rsp_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        model_last = 1'b1;
        bus.a0 = 4'd1; bus.b0 = 4'd1; bus.a1 = 4'd14; bus.b1 = 4'd3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        check("post_rst_first", {31'd0, pred(1'b1, 1'b1)}, 32'd0);
        wait_gnt(pred(1'b1, 1'b1), 1'b0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Counter wrap: 256 back-to-back ops on requester 0
        bus.a0 = 4'($urandom_range(0, 15));
        bus.b0 = 4'($urandom_range(0, 15));
        bus.req0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_gnt(pred(1'b1, 1'b0), i > 0);
            bus.a0 = 4'($urandom_range(0, 15));
            bus.b0 = 4'($urandom_range(0, 15));
        end
        bus.req0 = 1'b0;
        wait_idle();
        check("wrap_done", {24'd0, bus.done_cnt}, 32'd1);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Owns one instance of the team's 4-bit combinational `adder` (ports a, b, sum, cout) and shares it between two requesters.
- Round-robin arbitration between the requesters.
- Operands are registered before the add; the result is held in a response register until the consumer accepts it.
- Sits between requester logic and the ALU datapath, so that no requester drives the adder directly.

Parameters:
- WIDTH, 4, operand/sum width; must equal the `adder` width; no other value is supported.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request; held with a0/b0 until gnt0 is seen
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- gnt0  output  1  one-cycle grant pulse; operands of requester 0 were captured
- req1  input  1  requester 1 request
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- gnt1  output  1  one-cycle grant pulse for requester 1
- rsp_valid  output  1  response register holds an unconsumed result
- rsp_id  output  1  requester that owns the response (0/1)
- rsp_sum  output  WIDTH  adder sum
- rsp_cout  output  1  adder carry out
- rsp_ready  input  1  consumer accepts the response when high with rsp_valid
- busy  output  1  high whenever state != IDLE
- done_cnt  output  CNT_W  count of completed response handshakes

Behaviour:
- Reset:
  - state=IDLE; gnt0=gnt1=0; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_cout=0; done_cnt=0; busy=0.
  - Internal last_grant=1, so requester 0 wins the first tie.
- All outputs are registered; the adder inputs are driven only from the internal op_a/op_b registers.
- IDLE:
  - At an edge with req0|req1, select the winner, latch its operands into op_a/op_b and its id, pulse its gnt for exactly one cycle, and go to EXEC.
  - No request: stay in IDLE, gnts 0.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: winner = !last_grant.
  - last_grant updates to the winner at grant time.
  - Strict alternation results under continuous dual request.
- EXEC (one cycle):
  - At the next edge, capture {rsp_cout, rsp_sum} = op_a + op_b (5-bit result, no saturation), set rsp_valid=1 and rsp_id=winner, and go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - At an edge with rsp_ready=1: rsp_valid←0, done_cnt←done_cnt+1 (wraps 2^CNT_W−1→0), go to IDLE.
  - rsp_sum, rsp_cout and rsp_id keep their last values after rsp_valid falls.
- Requests during EXEC/RESP are ignored; no gnt is issued.
- A requester that still asserts req after its gnt is treated as a new request in the next IDLE.
- Latency:
  - Req sampled at edge t0 → gnt high t0..t1 → rsp_valid high from t1.
  - With rsp_ready held high: accepted at t2, IDLE at t2, next grant at t3.
  - Throughput is 1 op per 3 cycles.
- Reset mid-operation (EXEC or RESP): the pending result is discarded, no response is produced, and done_cnt returns to 0. The requester must reissue.
- busy=1 in EXEC and RESP.

Test Plan:
- Single add: req0=1, a0=0001, b0=0010 at t0 → gnt0 pulses 1 cycle, rsp_valid next cycle, rsp_id=0, rsp_sum=0011, rsp_cout=0, done_cnt=1 after ready handshake.
- Carry: req1=1, a1=1111, b1=0001 → rsp_id=1, rsp_sum=0000, rsp_cout=1; also a=0101, b=1010 → sum=1111, cout=0.
- Contention: req0 and req1 both held high continuously, rsp_ready=1 → grant order 0,1,0,1; rsp_id alternates accordingly; one grant every 3 cycles; done_cnt=4 after 4 responses.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_sum, rsp_cout and rsp_id stable, no gnt despite req1=1, busy=1. Raise rsp_ready → handshake, then gnt1 two cycles later.
- Reset mid-RESP: assert rst for 1 cycle while rsp_valid=1 → all outputs 0 next edge, done_cnt=0. With both requests high after reset, the first gnt goes to requester 0.
- Counter wrap: 256 back-to-back ops on req0 → done_cnt returns to 0; sums checked against a reference model each op.
